// File: rtl/gmii_tx_framer.sv
// Transmit MAC framer: AXI-stream bytes in, GMII frame out (preamble, SFD, payload, pad, FCS, IFG).
// Runs at 10/100/1000 by following the PHY interface clock-enable and MII nibble mode.
module gmii_tx_framer #(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MIN_IFG       = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  input  logic       clk_enable,
  input  logic       mii_select,
  input  logic [7:0] ifg_delay,
  output logic       start_packet,
  output logic       error_underflow
);

  localparam int unsigned PAD_LEN   = MIN_FRAME_LEN - 4;
  localparam logic [15:0] PAD_LEN_W = 16'(PAD_LEN);
  localparam logic [7:0]  MIN_IFG_W = 8'(MIN_IFG);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DROP, IFG
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        mii_q, mii_d;
  logic [7:0]  ifg_q, ifg_d;
  logic        half_q, half_d;
  logic [3:0]  nib_q, nib_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        sop_q, sop_d;
  logic        unf_q, unf_d;
  logic        tready_c;

  logic [7:0]  slot_byte;
  logic        slot_en;
  logic        slot_er;
  logic        slot_mii;
  logic [15:0] byte_inc_c;
  logic [7:0]  ifg_len_c;
  logic [31:0] fcs_c;
  logic [7:0]  fcs_byte_c;

  // Reflected CRC-32 (0x04C11DB7) advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  assign byte_inc_c = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
  assign ifg_len_c  = (ifg_q > MIN_IFG_W) ? ifg_q : MIN_IFG_W;
  assign fcs_c      = ~crc_q;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    fcs_byte_c = fcs_c[7:0];
      2'd1:    fcs_byte_c = fcs_c[15:8];
      2'd2:    fcs_byte_c = fcs_c[23:16];
      default: fcs_byte_c = fcs_c[31:24];
    endcase
  end

  // Next-state and output decision; frame decisions are taken only at byte-slot starts.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    mii_d      = mii_q;
    ifg_d      = ifg_q;
    half_d     = half_q;
    nib_d      = nib_q;
    txd_d      = txd_q;
    tx_en_d    = tx_en_q;
    tx_er_d    = tx_er_q;
    sop_d      = 1'b0;
    unf_d      = 1'b0;
    tready_c   = 1'b0;
    slot_byte  = 8'h00;
    slot_en    = 1'b0;
    slot_er    = 1'b0;
    slot_mii   = mii_q;

    if (clk_enable && half_q) begin
      // Second MII half: high nibble of the byte chosen at slot start, enables held.
      half_d = 1'b0;
      txd_d  = {4'h0, nib_q};
      if (state_q == DROP) begin
        tready_c = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = IFG;
          cnt_d   = 8'd0;
        end
      end
    end else if (clk_enable) begin
      half_d = mii_q;
      case (state_q)
        IDLE: begin
          half_d = 1'b0;
          if (s_axis_tvalid) begin
            state_d    = PREAMBLE;
            cnt_d      = 8'd1;
            byte_cnt_d = 16'd0;
            crc_d      = CRC_INIT;
            mii_d      = mii_select;
            ifg_d      = ifg_delay;
            half_d     = mii_select;
            slot_mii   = mii_select;
            sop_d      = 1'b1;
            slot_en    = 1'b1;
            slot_byte  = 8'h55;
          end
        end
        PREAMBLE: begin
          slot_en = 1'b1;
          if (cnt_q == 8'd7) begin
            slot_byte = 8'hD5;
            state_d   = PAYLOAD;
          end else begin
            slot_byte = 8'h55;
            cnt_d     = cnt_q + 8'd1;
          end
        end
        PAYLOAD: begin
          slot_en  = 1'b1;
          tready_c = 1'b1;
          if (s_axis_tvalid) begin
            slot_byte  = s_axis_tdata;
            crc_d      = crc32_byte(crc_q, s_axis_tdata);
            byte_cnt_d = byte_inc_c;
            if (s_axis_tlast) begin
              slot_er = s_axis_tuser;
              cnt_d   = 8'd0;
              state_d = (byte_inc_c < PAD_LEN_W) ? PAD : FCS;
            end
          end else begin
            slot_er = 1'b1;
            unf_d   = 1'b1;
            state_d = DROP;
          end
        end
        PAD: begin
          slot_en    = 1'b1;
          crc_d      = crc32_byte(crc_q, 8'h00);
          byte_cnt_d = byte_inc_c;
          if (byte_inc_c >= PAD_LEN_W) begin
            state_d = FCS;
            cnt_d   = 8'd0;
          end
        end
        FCS: begin
          slot_en   = 1'b1;
          slot_byte = fcs_byte_c;
          if (cnt_q == 8'd3) begin
            state_d = IFG;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DROP: begin
          tready_c = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) begin
            state_d = IFG;
            cnt_d   = 8'd0;
          end
        end
        IFG: begin
          if (({1'b0, cnt_q} + 9'd1) >= {1'b0, ifg_len_c}) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      txd_d   = slot_mii ? {4'h0, slot_byte[3:0]} : slot_byte;
      nib_d   = slot_byte[7:4];
      tx_en_d = slot_en;
      tx_er_d = slot_er;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 16'd0;
      crc_q      <= CRC_INIT;
      mii_q      <= 1'b0;
      ifg_q      <= 8'd0;
      half_q     <= 1'b0;
      nib_q      <= 4'h0;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      sop_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      mii_q      <= mii_d;
      ifg_q      <= ifg_d;
      half_q     <= half_d;
      nib_q      <= nib_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      sop_q      <= sop_d;
      unf_q      <= unf_d;
    end
  end

  assign s_axis_tready   = tready_c;
  assign gmii_txd        = txd_q;
  assign gmii_tx_en      = tx_en_q;
  assign gmii_tx_er      = tx_er_q;
  assign start_packet    = sop_q;
  assign error_underflow = unf_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Scoreboard bench for gmii_tx_framer: expected GMII bytes queued at stimulus time,
// popped as the monitor reassembles bytes (GMII or MII nibbles) from the outputs.
module tb_gmii_tx_framer;

  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

  typedef struct packed { logic uf; logic er; logic [7:0] b; } exp_t;
  typedef struct packed { logic fcs; logic [15:0] len; logic gap_v; logic [15:0] gap; } frm_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       clk_enable = 1'b1;
  logic       mii_select = 1'b0;
  logic [7:0] ifg_delay = 8'd12;
  logic       start_packet;
  logic       error_underflow;

  int   n_err = 0;
  int   n_chk = 0;
  exp_t sb[$];
  frm_t fq[$];

  int   ce_div = 1;
  int   ce_cnt = 0;
  logic ce_s = 1'b0;
  bit   mon_on = 1'b1;
  bit   mon_mii = 1'b0;
  bit   in_frame = 1'b0;
  bit   phase = 1'b0;
  logic [3:0]  lo_nib = 4'h0;
  logic        er0 = 1'b0;
  int          idx = 0;
  int          gap_cyc = 0;
  logic [31:0] mcrc = 32'hFFFF_FFFF;
  logic        last_gap_v = 1'b0;
  logic [15:0] last_gap = 16'd0;
  logic [7:0]  p_txd = 8'h00;
  logic        p_en = 1'b0;
  logic        p_er = 1'b0;
  int rd_cnt = 0;
  int sop_cnt = 0;
  int uf_cnt = 0;
  int exp_sop = 0;

  gmii_tx_framer #(.MIN_FRAME_LEN(64), .MIN_IFG(12)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .gmii_txd       (gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_tx_er     (gmii_tx_er),
    .clk_enable     (clk_enable),
    .mii_select     (mii_select),
    .ifg_delay      (ifg_delay),
    .start_packet   (start_packet),
    .error_underflow(error_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  // Clock-enable pattern: every cycle, or one cycle in ce_div.
  always @(posedge clk) begin
    #1;
    if (ce_div <= 1) begin
      clk_enable = 1'b1;
    end else begin
      ce_cnt = (ce_cnt + 1) % ce_div;
      clk_enable = (ce_cnt == 0);
    end
  end

  always @(posedge clk) ce_s = clk_enable;

  task automatic got_byte(input logic [7:0] b, input logic er);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underrun", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("byte", 32'({er, b}), 32'({e.er, e.b}));
      if (!mon_mii) check("uf_pulse", 32'(error_underflow), 32'(e.uf));
    end
    if (idx >= 8) mcrc = crc_upd(mcrc, b);
    idx++;
  endtask

  task automatic end_frame();
    frm_t f;
    if (fq.size() == 0) begin
      check("frame_underrun", 32'(fq.size()), 32'd1);
    end else begin
      f = fq.pop_front();
      check("frame_len", 32'(idx), 32'(f.len));
      if (f.fcs) check("residue", mcrc, RESIDUE);
      last_gap_v = f.gap_v;
      last_gap   = f.gap;
    end
  endtask

  // Monitor: samples outputs mid-cycle, rebuilds bytes and inter-frame gaps.
  always @(negedge clk) begin
    if (s_axis_tready) rd_cnt++;
    if (start_packet) sop_cnt++;
    if (error_underflow) uf_cnt++;
    if (mon_on) begin
      if (!ce_s) begin
        check("hold", 32'({gmii_txd, gmii_tx_en, gmii_tx_er}), 32'({p_txd, p_en, p_er}));
      end else if (gmii_tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          idx = 0;
          phase = 1'b0;
          mcrc = 32'hFFFF_FFFF;
          check("sop", 32'(start_packet), 32'd1);
          if (last_gap_v) check("gap", 32'(mon_mii ? gap_cyc / 2 : gap_cyc), 32'(last_gap));
          last_gap_v = 1'b0;
        end
        if (mon_mii) begin
          check("nib_hi", 32'(gmii_txd[7:4]), 32'd0);
          if (!phase) begin
            lo_nib = gmii_txd[3:0];
            er0 = gmii_tx_er;
            phase = 1'b1;
          end else begin
            phase = 1'b0;
            check("er_hold", 32'(gmii_tx_er), 32'(er0));
            got_byte({gmii_txd[3:0], lo_nib}, gmii_tx_er);
          end
        end else begin
          got_byte(gmii_txd, gmii_tx_er);
        end
      end else begin
        if (in_frame) begin
          end_frame();
          in_frame = 1'b0;
          gap_cyc = 0;
        end
        gap_cyc++;
      end
    end
    p_txd = gmii_txd;
    p_en  = gmii_tx_en;
    p_er  = gmii_tx_er;
  end

  task automatic drive_byte(input logic [7:0] d, input logic l, input logic u);
    bit acc;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    for (int k = 0; k < 4000 && !acc; k++) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("tready_timeout", 32'(acc), 32'd1);
  endtask

  // Queue the expected GMII image of a frame, then drive its payload.
  task automatic send_frame(input int len, input logic [7:0] base, input logic user,
                            input int uf_at, input logic [7:0] ifg, input int gap);
    logic [31:0] c;
    logic [7:0]  d;
    frm_t        f;
    int          n;
    for (int i = 0; i < 7; i++) sb.push_back('{1'b0, 1'b0, 8'h55});
    sb.push_back('{1'b0, 1'b0, 8'hD5});
    n = (uf_at >= 0) ? uf_at : len;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      d = 8'(int'(base) + i);
      sb.push_back('{1'b0, (user && i == len - 1), d});
      c = crc_upd(c, d);
    end
    if (uf_at >= 0) begin
      sb.push_back('{1'b1, 1'b1, 8'h00});
    end else begin
      for (int i = len; i < 60; i++) begin
        sb.push_back('{1'b0, 1'b0, 8'h00});
        c = crc_upd(c, 8'h00);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) sb.push_back('{1'b0, 1'b0, c[8*k +: 8]});
    end
    f.fcs   = (uf_at < 0);
    f.len   = 16'((uf_at >= 0) ? (8 + uf_at + 1) : (8 + ((len < 60) ? 60 : len) + 4));
    f.gap_v = (gap >= 0);
    f.gap   = 16'(gap);
    fq.push_back(f);
    ifg_delay = ifg;
    exp_sop++;
    for (int i = 0; i < len; i++) begin
      if (i == uf_at) begin
        s_axis_tvalid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
      drive_byte(8'(int'(base) + i), (i == len - 1), (user && i == len - 1));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb.size() != 0 || fq.size() != 0) && k < 20000) begin
      @(posedge clk);
      k++;
    end
    check("drain", 32'(sb.size() + fq.size()), 32'd0);
    repeat (300) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_txd"}, 32'(gmii_txd), 32'd0);
    check({pfx, "_tx_en"}, 32'(gmii_tx_en), 32'd0);
    check({pfx, "_tx_er"}, 32'(gmii_tx_er), 32'd0);
    check({pfx, "_tready"}, 32'(s_axis_tready), 32'd0);
    check({pfx, "_sop"}, 32'(start_packet), 32'd0);
    check({pfx, "_unf"}, 32'(error_underflow), 32'd0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    mon_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    mon_on = 1'b1;

    // GMII, 60-byte payload 0x00..0x3B: no pad
    send_frame(60, 8'h00, 1'b0, -1, 8'd12, -1);
    wait_idle();

    // Short payload padded to 60 bytes
    send_frame(10, 8'h40, 1'b0, -1, 8'd12, -1);
    wait_idle();

    // MII nibble mode with clock enable one cycle in five
    ce_div = 5;
    mii_select = 1'b1;
    mon_mii = 1'b1;
    rd_cnt = 0;
    send_frame(60, 8'h80, 1'b0, -1, 8'd12, -1);
    wait_idle();
    check("mii_tready", 32'(rd_cnt), 32'd60);
    ce_div = 1;
    mii_select = 1'b0;
    mon_mii = 1'b0;
    wait_idle();

    // Underflow after 20 bytes, rest drained
    uf_cnt = 0;
    send_frame(40, 8'hA0, 1'b0, 20, 8'd12, -1);
    wait_idle();
    check("uf_count", 32'(uf_cnt), 32'd1);

    // Back-to-back frames: gap floored at 12, then 20
    send_frame(30, 8'h10, 1'b0, -1, 8'd5, 12);
    send_frame(70, 8'h20, 1'b0, -1, 8'd20, 20);
    send_frame(15, 8'h30, 1'b0, -1, 8'd12, -1);
    wait_idle();

    // Bad frame flagged on tlast: error on last data slot only
    send_frame(64, 8'hC0, 1'b1, -1, 8'd12, -1);
    wait_idle();

    // Asynchronous reset in the middle of a payload
    mon_on = 1'b0;
    exp_sop++;
    for (int i = 0; i < 10; i++) drive_byte(8'(i), 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_frame = 1'b0;
    phase = 1'b0;
    last_gap_v = 1'b0;
    gap_cyc = 0;
    mon_on = 1'b1;
    send_frame(20, 8'h55, 1'b0, -1, 8'd12, -1);
    wait_idle();

    check("sop_count", 32'(sop_cnt), 32'(exp_sop));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
